// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue-stage hazard scoreboard: register index width,
// default sizing and the drain handshake state encoding.
package issue_scoreboard_pkg;

    localparam int REG_AW         = 5;
    localparam int SB_NUM_REGS    = 32;
    localparam int SB_MAX_PENDING = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_WAIT  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register: saturating up/down,
// flags an error on release-at-zero or increment-at-max.
module sb_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_d_o,
    output logic         err_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == W'(MAX)) err_o = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_o = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard: RAW/WAW stall, pending-write tracking and drain handshake.
// Optional macro SB_RELEASE_FORWARD_EN lets a source whose last write retires this cycle issue.
//
//   state | meaning
//   RUN   | normal issue, hazards permitting
//   DRAIN | issue blocked until every pending write has retired
//   DONE  | drain_done pulse (one cycle)
//   WAIT  | hold until drain_req drops, so a held request cannot retrigger
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int MAX_PENDING = SB_MAX_PENDING
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              head_valid,
    input  logic [REG_AW-1:0] head_rs1_addr,
    input  logic              head_rs1_used,
    input  logic [REG_AW-1:0] head_rs2_addr,
    input  logic              head_rs2_used,
    input  logic [REG_AW-1:0] head_rd_addr,
    input  logic              head_rd_we,
    input  logic              exe_busy,
    input  logic              rel_en,
    input  logic [REG_AW-1:0] rel_addr,
    input  logic              drain_req,
    output logic              issue_go,
    output logic              drain_done,
    output logic              pending_any,
    output logic              sb_error
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:1] err;

    drain_state_e state_q, state_d;
    logic         pending_any_q;
    logic         sb_error_q;
    logic         any_d;
    logic         fwd1, fwd2;
    logic         hazard;

    // x0 is never tracked: its count is constant zero
    assign cnt_q[0] = '0;
    assign cnt_d[0] = '0;

`ifdef SB_RELEASE_FORWARD_EN
    assign fwd1 = rel_en && (rel_addr == head_rs1_addr) && (cnt_q[head_rs1_addr] == CNT_W'(1));
    assign fwd2 = rel_en && (rel_addr == head_rs2_addr) && (cnt_q[head_rs2_addr] == CNT_W'(1));
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign hazard =
        (head_rs1_used && (head_rs1_addr != '0) && (cnt_q[head_rs1_addr] != '0) && !fwd1) ||
        (head_rs2_used && (head_rs2_addr != '0) && (cnt_q[head_rs2_addr] != '0) && !fwd2) ||
        (head_rd_we && (head_rd_addr != '0) && (cnt_q[head_rd_addr] == CNT_W'(MAX_PENDING)));

    // A new drain request blocks issue in the same cycle it is seen
    assign issue_go = rst_n && head_valid && !exe_busy && !flush && !hazard &&
                      (state_q == ST_RUN) && !drain_req;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc_r, dec_r;
        assign inc_r = issue_go && head_rd_we && (head_rd_addr == REG_AW'(r));
        assign dec_r = rel_en && (rel_addr == REG_AW'(r));

        sb_counter #(
            .MAX (MAX_PENDING),
            .W   (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc_r),
            .dec_i   (dec_r),
            .cnt_o   (cnt_q[r]),
            .cnt_d_o (cnt_d[r]),
            .err_o   (err[r])
        );
    end

    always_comb begin
        any_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            any_d = any_d | (cnt_d[r] != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (!any_d)    state_d = ST_DONE;
            ST_DONE:                 state_d = ST_WAIT;
            ST_WAIT:  if (!drain_req) state_d = ST_RUN;
            default:                 state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pending_any_q <= 1'b0;
            sb_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_any_q <= any_d;
            sb_error_q    <= sb_error_q | (|err);
        end
    end

    assign drain_done  = (state_q == ST_DONE);
    assign pending_any = pending_any_q;
    assign sb_error    = sb_error_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic against a per-register pending-count model.
module tb_issue_scoreboard;

`ifdef SB_RELEASE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, head_valid, head_rs1_used, head_rs2_used, head_rd_we;
    logic [4:0] head_rs1_addr, head_rs2_addr, head_rd_addr, rel_addr;
    logic       exe_busy, rel_en, drain_req;
    logic       issue_go, drain_done, pending_any, sb_error;

    int tests = 0;
    int fails = 0;

    // reference model
    int mcnt [32];
    bit merr;
    int mphase; // 0 run, 1 draining, 2 done pulse, 3 waiting for request release

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .head_valid    (head_valid),
        .head_rs1_addr (head_rs1_addr),
        .head_rs1_used (head_rs1_used),
        .head_rs2_addr (head_rs2_addr),
        .head_rs2_used (head_rs2_used),
        .head_rd_addr  (head_rd_addr),
        .head_rd_we    (head_rd_we),
        .exe_busy      (exe_busy),
        .rel_en        (rel_en),
        .rel_addr      (rel_addr),
        .drain_req     (drain_req),
        .issue_go      (issue_go),
        .drain_done    (drain_done),
        .pending_any   (pending_any),
        .sb_error      (sb_error)
    );

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr   = 0;
        mphase = 0;
    endtask

    function automatic bit src_blocks(logic used, logic [4:0] a);
        if (!used || a == 0 || mcnt[a] == 0) return 0;
        if (FWD && rel_en && rel_addr == a && mcnt[a] == 1) return 0;
        return 1;
    endfunction

    function automatic bit exp_go();
        bit haz;
        haz = src_blocks(head_rs1_used, head_rs1_addr) ||
              src_blocks(head_rs2_used, head_rs2_addr) ||
              (head_rd_we && head_rd_addr != 0 && mcnt[head_rd_addr] >= 3);
        return rst_n && head_valid && !exe_busy && !flush && !haz && mphase == 0 && !drain_req;
    endfunction

    function automatic bit model_pending();
        for (int r = 1; r < 32; r++) if (mcnt[r] != 0) return 1;
        return 0;
    endfunction

    task automatic model_step();
        bit go, inc, dec;
        if (!rst_n) begin
            model_reset();
            return;
        end
        go = exp_go();
        for (int r = 1; r < 32; r++) begin
            inc = go && head_rd_we && head_rd_addr == r;
            dec = rel_en && rel_addr == r;
            if (inc && !dec) begin
                if (mcnt[r] == 3) merr = 1; else mcnt[r]++;
            end else if (dec && !inc) begin
                if (mcnt[r] == 0) merr = 1; else mcnt[r]--;
            end
        end
        case (mphase)
            0: if (drain_req) mphase = 1;
            1: if (!model_pending()) mphase = 2;
            2: mphase = 3;
            default: if (!drain_req) mphase = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; head_valid = 0; head_rs1_used = 0; head_rs2_used = 0; head_rd_we = 0;
        head_rs1_addr = 0; head_rs2_addr = 0; head_rd_addr = 0;
        exe_busy = 0; rel_en = 0; rel_addr = 0; drain_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        head_valid = 1;
        #2;
        tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL reset_go: issue_go=%0b expected 0", issue_go); end
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL reset_pending: pending_any=%0b expected 0", pending_any); end
        tests++; if (drain_done !== 1'b0) begin fails++; $display("FAIL reset_done: drain_done=%0b expected 0", drain_done); end
        tests++; if (sb_error !== 1'b0) begin fails++; $display("FAIL reset_err: sb_error=%0b expected 0", sb_error); end
        @(posedge clk); #1;
        rst_n = 1;
        head_valid = 0;
        tick();
    endtask

    task automatic test_raw();
        head_valid = 1; head_rd_we = 1; head_rd_addr = 5;
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL raw_producer: issue_go=%0b expected 1", issue_go); end
        tick();
        head_rd_we = 0; head_rs1_used = 1; head_rs1_addr = 5;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL raw_stall: cycle %0d issue_go=%0b expected 0", i, issue_go); end
            tick();
        end
        rel_en = 1; rel_addr = 5;
        #1;
        tests++; if (issue_go !== FWD) begin fails++; $display("FAIL raw_release_cycle: issue_go=%0b expected %0b", issue_go, FWD); end
        tick();
        rel_en = 0;
        if (FWD) head_valid = 0;
        #1;
        tests++; if (issue_go !== !FWD) begin fails++; $display("FAIL raw_after_release: issue_go=%0b expected %0b", issue_go, !FWD); end
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL raw_pending: pending_any=%0b expected 0", pending_any); end
        tick();
        idle_inputs();
    endtask

    task automatic test_waw();
        head_valid = 1; head_rd_we = 1; head_rd_addr = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL waw_issue: write %0d issue_go=%0b expected 1", i, issue_go); end
            tick();
        end
        #1;
        tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL waw_saturated: issue_go=%0b expected 0", issue_go); end
        tick();
        rel_en = 1; rel_addr = 7;
        #1;
        tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL waw_release_cycle: issue_go=%0b expected 0", issue_go); end
        tick();
        rel_en = 0;
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL waw_after_release: issue_go=%0b expected 1", issue_go); end
        tick();
        head_valid = 0; rel_en = 1; rel_addr = 7;
        for (int i = 0; i < 3; i++) tick();
        rel_en = 0;
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL waw_cleanup: pending_any=%0b expected 0", pending_any); end
        tests++; if (sb_error !== 1'b0) begin fails++; $display("FAIL waw_err: sb_error=%0b expected 0", sb_error); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        head_valid = 1; head_rd_we = 1; head_rd_addr = 3;
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL simul_first: issue_go=%0b expected 1", issue_go); end
        tick();
        rel_en = 1; rel_addr = 3;
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL simul_issue: issue_go=%0b expected 1", issue_go); end
        tick();
        tests++; if (pending_any !== 1'b1) begin fails++; $display("FAIL simul_pending: pending_any=%0b expected 1", pending_any); end
        head_valid = 0;
        tick();
        rel_en = 0;
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL simul_count_one: pending_any=%0b expected 0", pending_any); end
        tests++; if (sb_error !== 1'b0) begin fails++; $display("FAIL simul_err: sb_error=%0b expected 0", sb_error); end
        idle_inputs();
    endtask

    task automatic test_drain();
        int rels [7] = '{0, 0, 1, 2, 0, 0, 0};
        int pulses = 0;
        head_valid = 1; head_rd_we = 1;
        head_rd_addr = 1; tick();
        head_rd_addr = 2; tick();
        head_rd_we = 0; head_rd_addr = 0;
        drain_req = 1;
        for (int i = 0; i < 7; i++) begin
            rel_en = (rels[i] != 0);
            rel_addr = 5'(rels[i]);
            #1;
            tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL drain_block: cycle %0d issue_go=%0b expected 0", i, issue_go); end
            tick();
            if (drain_done === 1'b1) pulses++;
            tests++; if (drain_done !== (i == 3)) begin fails++; $display("FAIL drain_done: after cycle %0d drain_done=%0b expected %0b", i, drain_done, (i == 3)); end
        end
        rel_en = 0;
        tests++; if (pulses != 1) begin fails++; $display("FAIL drain_pulses: got %0d pulses expected 1", pulses); end
        drain_req = 0;
        #1;
        tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL drain_wait: issue_go=%0b expected 0", issue_go); end
        tick();
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL drain_resume: issue_go=%0b expected 1", issue_go); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            head_valid    = ($urandom % 4) != 0;
            head_rs1_used = $urandom % 2;
            head_rs1_addr = 5'($urandom % 8);
            head_rs2_used = $urandom % 2;
            head_rs2_addr = 5'($urandom % 8);
            head_rd_we    = $urandom % 2;
            head_rd_addr  = 5'($urandom % 8);
            exe_busy      = ($urandom % 5) == 0;
            flush         = ($urandom % 8) == 0;
            if (($urandom % 20) == 0) drain_req = !drain_req;
            r = 1 + ($urandom % 7);
            rel_addr = 5'(r);
            rel_en   = (mcnt[r] > 0) && ($urandom % 2);
            #1;
            tests++; if (issue_go !== exp_go()) begin fails++; $display("FAIL rand_go: cycle %0d issue_go=%0b expected %0b", cyc, issue_go, exp_go()); end
            tick();
            tests++; if (pending_any !== model_pending()) begin fails++; $display("FAIL rand_pending: cycle %0d pending_any=%0b expected %0b", cyc, pending_any, model_pending()); end
            tests++; if (drain_done !== (mphase == 2)) begin fails++; $display("FAIL rand_done: cycle %0d drain_done=%0b expected %0b", cyc, drain_done, (mphase == 2)); end
            tests++; if (sb_error !== merr) begin fails++; $display("FAIL rand_err: cycle %0d sb_error=%0b expected %0b", cyc, sb_error, merr); end
        end
        idle_inputs();
        for (int q = 1; q < 32; q++) begin
            while (mcnt[q] > 0) begin
                rel_en = 1; rel_addr = 5'(q);
                tick();
            end
        end
        rel_en = 0;
        for (int i = 0; i < 4; i++) tick();
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL rand_cleanup: pending_any=%0b expected 0", pending_any); end
    endtask

    task automatic test_flush_x0_err();
        head_valid = 1; head_rd_we = 1; head_rd_addr = 4; flush = 1;
        #1;
        tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL flush_go: issue_go=%0b expected 0", issue_go); end
        tick();
        flush = 0;
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL flush_counters: pending_any=%0b expected 0", pending_any); end
        head_rd_addr = 0;
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL x0_issue: issue_go=%0b expected 1", issue_go); end
        tick();
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL x0_untracked: pending_any=%0b expected 0", pending_any); end
        head_valid = 0; head_rd_we = 0;
        rel_en = 1; rel_addr = 0;
        tick();
        tests++; if (sb_error !== 1'b0) begin fails++; $display("FAIL x0_release_err: sb_error=%0b expected 0", sb_error); end
        rel_addr = 9;
        tick();
        rel_en = 0;
        tests++; if (sb_error !== 1'b1) begin fails++; $display("FAIL underflow_err: sb_error=%0b expected 1", sb_error); end
        for (int i = 0; i < 3; i++) tick();
        tests++; if (sb_error !== 1'b1) begin fails++; $display("FAIL err_sticky: sb_error=%0b expected 1", sb_error); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        head_valid = 1; head_rd_we = 1; head_rd_addr = 1;
        tick();
        head_valid = 0; head_rd_we = 0; drain_req = 1;
        tick();
        tick();
        head_valid = 1;
        #2;
        rst_n = 0;
        #1;
        tests++; if (pending_any !== 1'b0) begin fails++; $display("FAIL areset_pending: pending_any=%0b expected 0", pending_any); end
        tests++; if (drain_done !== 1'b0) begin fails++; $display("FAIL areset_done: drain_done=%0b expected 0", drain_done); end
        tests++; if (sb_error !== 1'b0) begin fails++; $display("FAIL areset_err: sb_error=%0b expected 0", sb_error); end
        tests++; if (issue_go !== 1'b0) begin fails++; $display("FAIL areset_go: issue_go=%0b expected 0", issue_go); end
        model_reset();
        drain_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        tests++; if (issue_go !== 1'b1) begin fails++; $display("FAIL areset_run: issue_go=%0b expected 1", issue_go); end
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_simultaneous();
        test_drain();
        test_random();
        test_flush_x0_err();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Hazard scheduler for the in-order issue stage; decides each cycle whether the microcode at the head of the issue queue may leave for execute.
- Tracks per-register pending-write counts; stalls on RAW (source pending) and on per-register counter saturation (WAW depth).
- Provides a serialising drain handshake (fence/CSR): blocks issue until every pending write has retired.
- Sits between the issue queue/register-file read and the execute stage; its issue_go drives the queue read enable.

Parameters:
- NUM_REGS, 32, integer register count; index 0 is hard-wired zero and never tracked.
- MAX_PENDING, 3, max outstanding writes per register; counter width CNT_W = $clog2(MAX_PENDING+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch mispredict; discards the unissued head only
- head_valid  in  1  issue queue non-empty
- head_rs1_addr  in  5  source 1 register index
- head_rs1_used  in  1  source 1 is read
- head_rs2_addr  in  5  source 2 register index
- head_rs2_used  in  1  source 2 is read
- head_rd_addr  in  5  destination register index
- head_rd_we  in  1  head writes rd
- exe_busy  in  1  execute cannot accept
- rel_en  in  1  one issued rd-writing op retires or is squashed this cycle
- rel_addr  in  5  rd of the releasing op
- drain_req  in  1  level request: empty the pipeline of pending writes
- issue_go  out  1  combinational: head issues this cycle
- drain_done  out  1  one-cycle pulse when the drain completes
- pending_any  out  1  some counter is non-zero
- sb_error  out  1  sticky: release with count 0, or counter overflow

Behaviour:
- Reset (async, rst_n=0): all counters 0, FSM=RUN, drain_done=0, sb_error=0; issue_go=0 while reset is asserted.
- hazard = (rs1_used & rs1!=0 & cnt[rs1]!=0 & !fwd1) | (rs2_used & rs2!=0 & cnt[rs2]!=0 & !fwd2) | (rd_we & rd!=0 & cnt[rd]==MAX_PENDING).
- fwdN: see Optional Feature; it is 0 when the feature is absent.
- issue_go = head_valid & !exe_busy & !flush & !hazard & (state==RUN); zero added latency.
- Counter update (registered, per register r!=0):
  - inc = issue_go & head_rd_we & head_rd_addr==r; dec = rel_en & rel_addr==r.
  - inc & dec: count unchanged. inc only: +1. dec only: -1.
  - dec at count 0: count stays 0, sb_error set. inc at MAX_PENDING cannot occur (stalled); if it does, count saturates and sb_error is set.
- Writes or releases to x0 are ignored and never raise sb_error.
- Flush: suppresses issue_go in the same cycle; counters are untouched. Every issued write still produces exactly one rel_en, committed or squashed.
- pending_any is registered, derived from the next-state counters; it is 0 in the cycle after the last release.
- FSM:
  - RUN: drain_req=1 -> DRAIN (issue_go is already blocked in that cycle).
  - DRAIN: issue_go=0. When all next-state counters are zero -> DONE.
  - DONE: drain_done=1 for one cycle, then -> WAIT.
  - WAIT: hold until drain_req=0, then -> RUN. A request held high does not retrigger.
  - A flush in any state does not change FSM state.
- sb_error clears only on reset.

Optional Feature:
- Macro SB_RELEASE_FORWARD_EN.
- Defined: fwdN = rel_en & rel_addr==rsN & cnt[rsN]==1. A source whose last pending write retires this cycle does not stall. This is valid because register-file read bypasses same-cycle writeback.
- Undefined: fwdN=0; the dependent op issues one cycle after the release.

Decomposition:
- Shared core package: register-index width (5), NUM_REGS, drain FSM state enum (RUN/DRAIN/DONE/WAIT).
- One sub-module, sb_counter: a single saturating up/down counter with inc/dec/err outputs, instantiated NUM_REGS-1 times via generate.
- Hazard logic, FSM and reductions stay at top level.

Test Plan:
- RAW stall: issue rd=x5, then head reads rs1=x5. Expect issue_go=0 until rel_en/rel_addr=5. With SB_RELEASE_FORWARD_EN, issue_go=1 in the release cycle; without it, one cycle later.
- WAW saturation: issue three writes to x7 with no release. Expect the fourth rd=x7 write stalled. One release of x7 -> issue_go=1 next cycle.
- Simultaneous inc/dec: cnt[x3]=1, issue rd=x3 while rel_addr=3 in the same cycle. Expect cnt[x3] stays 1 and pending_any=1.
- Drain: two pending writes (x1, x2) with drain_req=1. Expect issue_go=0 throughout; drain_done pulses exactly once, one cycle after the second release. No retrigger while drain_req stays high; RUN resumes after drain_req=0.
- Flush + x0 + error: flush with a valid, hazard-free head -> issue_go=0 and counters unchanged. Issue rd=x0 -> no count change. rel_en on x9 at count 0 -> sb_error=1 and stays 1 until reset.
- Async reset mid-drain: assert rst_n=0 with no clk edge. Expect counters 0, FSM=RUN, drain_done=0 and sb_error=0 immediately.
